key_input_ctrl: RTL and testbench
=================================

KEY_INPUT_CTRL -- requirements
Module: key_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles needed to accept a level change (10 ms at 25 MHz).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 12500000: hold time between auto-repeat events (0.5 s); used only under KEY_AUTOREPEAT_EN.
REQ-003 SHALL have port clock_25  input  1  the only clock, 25 MHz.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port key_right_n  input  1  raw asynchronous push-button, active-low.
REQ-006 SHALL have port key_left_n  input  1  raw asynchronous push-button, active-low.
REQ-007 SHALL have port game_tik  input  1  one-cycle game-step strobe; consumes pending commands.
REQ-008 SHALL have port right_P  output  1  turn-right command, valid only while game_tik=1.
REQ-009 SHALL have port left_P  output  1  turn-left command, valid only while game_tik=1.
REQ-010 SHALL have port cmd_pending  output  1  a command is latched and awaiting game_tik.

Function
REQ-011 Each raw key SHALL pass through a 2-flop synchronizer; the debounce logic SHALL see only the second flop's output (2-cycle input latency).
REQ-012 Each key SHALL have its own FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 RELEASED->PRESS_WAIT on synchronized low; PRESS_WAIT->PRESSED after DEBOUNCE_CYCLES consecutive low cycles; any high cycle in PRESS_WAIT returns to RELEASED and clears the counter.
REQ-014 PRESSED->RELEASE_WAIT on synchronized high; RELEASE_WAIT->RELEASED after DEBOUNCE_CYCLES consecutive high cycles; any low cycle returns to PRESSED.
REQ-015 The PRESS_WAIT->PRESSED transition SHALL generate exactly one press event per key, in the transition cycle.
REQ-016 A press event SHALL set that key's pending flag in the next cycle; the new event SHALL clear the other key's pending flag (last press wins).
REQ-017 Right and left events in the same cycle SHALL both be discarded and both pending flags cleared.
REQ-018 right_P SHALL equal pend_right AND game_tik; left_P SHALL equal pend_left AND game_tik; they SHALL never both be 1.
REQ-019 Each pending flag SHALL clear in the cycle after game_tik=1 samples it, unless a new event for that key arrives in the same cycle, in which case it stays set.
REQ-020 An event and game_tik in the same cycle: that event SHALL NOT appear at that game_tik; it SHALL be delivered at the next game_tik.
REQ-021 cmd_pending SHALL equal pend_right OR pend_left.
REQ-022 Debounce counters SHALL saturate at DEBOUNCE_CYCLES-1, never wrap; width = $clog2(DEBOUNCE_CYCLES).

Reset
REQ-023 With reset=0 at a rising clock_25 edge: FSMs SHALL go to RELEASED, counters and pending flags to 0, synchronizer flops to 1 (released).
REQ-024 During and in the first cycle after reset, right_P, left_P and cmd_pending SHALL be 0; a key held through reset SHALL produce one event only after full debounce following reset release.

Configuration
REQ-025 With KEY_AUTOREPEAT_EN defined: a key staying in PRESSED SHALL generate a further press event every REPEAT_CYCLES cycles, counter restarting at each event and cleared on leaving PRESSED.
REQ-026 Without KEY_AUTOREPEAT_EN: one event per press; no repeat counter SHALL be synthesized.

Structure
REQ-027 FSM state encoding (2-bit typedef) and default DEBOUNCE_CYCLES/REPEAT_CYCLES constants SHALL live in shared package snake_pkg.
REQ-028 Synchronizer, debounce FSM, counter (and repeat counter) SHALL form one sub-module key_debounce, instantiated twice; key_input_ctrl holds the pending/arbitration logic.

Verification (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20)
REQ-029 Clean press: key_right_n low for 10 cycles, game_tik 3 cycles after the event -> right_P=1 for exactly that cycle, cmd_pending 1->0 the next cycle.
REQ-030 Bounce: key_left_n toggling every 2 cycles for 20 cycles, then high -> no event, cmd_pending stays 0.
REQ-031 Override: right event, then left event before game_tik -> at game_tik left_P=1, right_P=0.
REQ-032 Collision: both keys low in the same cycle for 10 cycles -> both events discarded, cmd_pending=0, no command at next game_tik.
REQ-033 Event coincident with game_tik -> no command that tik; command at the following game_tik.
REQ-034 Reset mid-PRESS_WAIT with key held -> outputs 0; event only after 4 low cycles plus 2 sync cycles after reset=1; with KEY_AUTOREPEAT_EN, holding 50 cycles after the event -> 2 repeat events.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and default timing for the push-button front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snake_pkg;

    typedef enum logic [1:0] {
        KEY_RELEASED     = 2'd0,
        KEY_PRESS_WAIT   = 2'd1,
        KEY_PRESSED      = 2'd2,
        KEY_RELEASE_WAIT = 2'd3
    } key_state_t;

    // 10 ms debounce and 0.5 s auto-repeat at 25 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int REPEAT_CYCLES_DEF   = 12500000;

    typedef struct packed {
        logic right;
        logic left;
    } key_evt_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, debounce FSM, press-event strobe (KEY_AUTOREPEAT_EN adds repeats).
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable low cycles to the press event.
// Backpressure: none; press_evt is a single-cycle strobe.
module key_debounce
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clock_25,
    input  logic reset,
    input  logic key_n,
    output logic press_evt
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          key_low;
    key_state_t    state;
    logic [CW-1:0] cnt;
    logic          press_done;

    assign key_low = ~sync_q[1];

    // The cycle that enters a WAIT state counts as the first stable cycle,
    // so the counter never has to go past DEBOUNCE_CYCLES-1.
    assign press_done = (state == KEY_PRESS_WAIT) && key_low && (cnt == CNT_LAST);

    always_ff @(posedge clock_25) begin
        if (!reset) begin
            sync_q <= 2'b11;
            state  <= KEY_RELEASED;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            unique case (state)
                KEY_RELEASED: begin
                    if (key_low) begin
                        state <= KEY_PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                KEY_PRESS_WAIT: begin
                    if (!key_low) begin
                        state <= KEY_RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= KEY_PRESSED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                KEY_PRESSED: begin
                    if (!key_low) begin
                        state <= KEY_RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                KEY_RELEASE_WAIT: begin
                    if (key_low) begin
                        state <= KEY_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= KEY_RELEASED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= KEY_RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int               REP_W    = cnt_width(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_fire;
    logic             holding;

    assign holding  = (state == KEY_PRESSED) && key_low;
    assign rep_fire = holding && (rep_cnt == REP_LAST);

    always_ff @(posedge clock_25) begin
        if (!reset) begin
            rep_cnt <= '0;
        end else if (holding) begin
            rep_cnt <= rep_fire ? '0 : rep_cnt + REP_ONE;
        end else begin
            rep_cnt <= '0;
        end
    end

    assign press_evt = press_done | rep_fire;
`else
    // Repeat timing is compiled out in this build.
    localparam int unused_repeat_cycles = REPEAT_CYCLES;

    assign press_evt = press_done;
`endif

endmodule

// File: rtl/key_input_ctrl.sv
// Turns two debounced buttons into one pending turn command consumed by game_tik (KEY_AUTOREPEAT_EN: auto-repeat).
// Latency: press event -> pending flag 1 cycle; right_P/left_P combinational with game_tik.
// Backpressure: a command waits in its pending flag until game_tik; a newer press overwrites it.
module key_input_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clock_25,
    input  logic reset,
    input  logic key_right_n,
    input  logic key_left_n,
    input  logic game_tik,
    output logic right_P,
    output logic left_P,
    output logic cmd_pending
);

    logic     right_evt;
    logic     left_evt;
    key_evt_t pend;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_key_right (
        .clock_25  (clock_25),
        .reset     (reset),
        .key_n     (key_right_n),
        .press_evt (right_evt)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_key_left (
        .clock_25  (clock_25),
        .reset     (reset),
        .key_n     (key_left_n),
        .press_evt (left_evt)
    );

    // Newest press wins; simultaneous presses are ambiguous and drop both.
    // A press arriving with game_tik is kept for the following tik.
    always_ff @(posedge clock_25) begin
        if (!reset) begin
            pend <= '0;
        end else if (right_evt && left_evt) begin
            pend <= '0;
        end else if (right_evt) begin
            pend.right <= 1'b1;
            pend.left  <= 1'b0;
        end else if (left_evt) begin
            pend.right <= 1'b0;
            pend.left  <= 1'b1;
        end else if (game_tik) begin
            pend <= '0;
        end
    end

    // The flags are mutually exclusive, so the two commands never coincide.
    assign right_P     = pend.right & game_tik;
    assign left_P      = pend.left  & game_tik;
    assign cmd_pending = pend.right | pend.left;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed and random stimulus for key_input_ctrl against a run-length reference model.
module tb_key_input_ctrl;

    localparam int DEB = 4;
    localparam int REP = 20;

    logic clock_25    = 1'b0;
    logic reset       = 1'b0;
    logic key_right_n = 1'b1;
    logic key_left_n  = 1'b1;
    logic game_tik    = 1'b0;
    logic right_P;
    logic left_P;
    logic cmd_pending;

    int n_checks    = 0;
    int n_pass      = 0;
    int n_left_seen = 0;

    always #5 clock_25 = ~clock_25;

    key_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clock_25    (clock_25),
        .reset       (reset),
        .key_right_n (key_right_n),
        .key_left_n  (key_left_n),
        .game_tik    (game_tik),
        .right_P     (right_P),
        .left_P      (left_P),
        .cmd_pending (cmd_pending)
    );

    // Reference model, index 0 = right, 1 = left.
    // dly: raw key seen two edges late; lvl: accepted level (1 = pressed);
    // run: consecutive cycles the synchronized key has disagreed with lvl;
    // rep: consecutive cycles held while fully pressed.
    bit [1:0] m_dly [2] = '{2'b11, 2'b11};
    bit       m_lvl [2] = '{1'b0, 1'b0};
    int       m_run [2] = '{0, 0};
    int       m_rep [2] = '{0, 0};
    bit       m_pr = 1'b0;
    bit       m_pl = 1'b0;

    always @(posedge clock_25) begin
        bit raw [2];
        bit ev  [2];
        bit syn_low;
        raw[0] = key_right_n;
        raw[1] = key_left_n;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_dly[k] = 2'b11;
                m_lvl[k] = 1'b0;
                m_run[k] = 0;
                m_rep[k] = 0;
            end
            m_pr = 1'b0;
            m_pl = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                ev[k]   = 1'b0;
                syn_low = !m_dly[k][1];
`ifdef KEY_AUTOREPEAT_EN
                if (m_lvl[k] && m_run[k] == 0 && syn_low) begin
                    m_rep[k]++;
                    if (m_rep[k] == REP) begin
                        ev[k]    = 1'b1;
                        m_rep[k] = 0;
                    end
                end else begin
                    m_rep[k] = 0;
                end
`endif
                if (syn_low != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_lvl[k] = !m_lvl[k];
                        m_run[k] = 0;
                        if (m_lvl[k]) ev[k] = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_dly[k] = {m_dly[k][0], raw[k]};
            end
            if (ev[0] && ev[1]) begin
                m_pr = 1'b0;
                m_pl = 1'b0;
            end else if (ev[0]) begin
                m_pr = 1'b1;
                m_pl = 1'b0;
            end else if (ev[1]) begin
                m_pr = 1'b0;
                m_pl = 1'b1;
            end else if (game_tik) begin
                m_pr = 1'b0;
                m_pl = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    endtask

    task automatic check_model();
        chk("right_P", right_P, m_pr & game_tik);
        chk("left_P", left_P, m_pl & game_tik);
        chk("cmd_pending", cmd_pending, m_pr | m_pl);
        chk("onehot", right_P & left_P, 1'b0);
        if (left_P === 1'b1) n_left_seen++;
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked at the falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock_25);
            check_model();
            @(posedge clock_25);
            #1;
        end
    endtask

    initial begin
        int hold;
        int pat;
        @(posedge clock_25);
        #1;
        step(3);
        chk("rst_cmd", cmd_pending, 1'b0);
        reset    = 1'b1;
        game_tik = 1'b1;
        #1;
        chk("rst_first_right", right_P, 1'b0);
        chk("rst_first_left", left_P, 1'b0);
        step(1);
        game_tik = 1'b0;

        // Clean press, tik three cycles after the event
        key_right_n = 1'b0;
        step(6);
        #1;
        chk("clean_pend", cmd_pending, 1'b1);
        step(2);
        game_tik = 1'b1;
        #1;
        chk("clean_right", right_P, 1'b1);
        chk("clean_left", left_P, 1'b0);
        step(1);
        game_tik = 1'b0;
        #1;
        chk("clean_clear", cmd_pending, 1'b0);
        step(1);
        key_right_n = 1'b1;
        step(12);

        // Bounce: no run of lows is long enough
        for (int i = 0; i < 10; i++) begin
            key_left_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        key_left_n = 1'b1;
        step(10);
        chk("bounce_pend", cmd_pending, 1'b0);
        game_tik = 1'b1;
        #1;
        chk("bounce_left", left_P, 1'b0);
        step(1);
        game_tik = 1'b0;

        // Override: later left press replaces pending right
        key_right_n = 1'b0;
        step(10);
        key_right_n = 1'b1;
        key_left_n  = 1'b0;
        step(8);
        game_tik = 1'b1;
        #1;
        chk("override_left", left_P, 1'b1);
        chk("override_right", right_P, 1'b0);
        step(1);
        game_tik   = 1'b0;
        key_left_n = 1'b1;
        step(12);

        // Collision: simultaneous presses cancel
        key_right_n = 1'b0;
        key_left_n  = 1'b0;
        step(8);
        chk("collide_pend", cmd_pending, 1'b0);
        game_tik = 1'b1;
        #1;
        chk("collide_right", right_P, 1'b0);
        chk("collide_left", left_P, 1'b0);
        step(1);
        game_tik = 1'b0;
        step(1);
        key_right_n = 1'b1;
        key_left_n  = 1'b1;
        step(12);

        // Event in the same cycle as game_tik is held for the next tik
        key_right_n = 1'b0;
        step(5);
        game_tik = 1'b1;
        #1;
        chk("coinc_none", right_P, 1'b0);
        step(1);
        game_tik = 1'b0;
        #1;
        chk("coinc_pend", cmd_pending, 1'b1);
        step(2);
        game_tik = 1'b1;
        #1;
        chk("coinc_next", right_P, 1'b1);
        step(1);
        game_tik    = 1'b0;
        key_right_n = 1'b1;
        step(12);

        // Reset in the middle of PRESS_WAIT with the key held
        key_left_n = 1'b0;
        step(4);
        reset    = 1'b0;
        game_tik = 1'b1;
        step(2);
        #1;
        chk("midrst_cmd", cmd_pending, 1'b0);
        chk("midrst_left", left_P, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_after_cmd", cmd_pending, 1'b0);
        chk("midrst_after_left", left_P, 1'b0);
        game_tik = 1'b0;
        step(5);
        #1;
        chk("midrst_wait", cmd_pending, 1'b0);
        step(1);
        #1;
        chk("midrst_evt", cmd_pending, 1'b1);
        n_left_seen = 0;
        game_tik    = 1'b1;
        step(50);
        game_tik = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        chk("hold_cmds", n_left_seen, 3);
`else
        chk("hold_cmds", n_left_seen, 1);
`endif
        key_left_n = 1'b1;
        step(12);

        // Random key levels and tiks, with occasional reset
        for (int i = 0; i < 70; i++) begin
            pat         = $urandom_range(0, 3);
            key_right_n = pat[0];
            key_left_n  = pat[1];
            hold        = $urandom_range(1, 12);
            if ($urandom_range(0, 29) == 0) reset = 1'b0;
            for (int c = 0; c < hold; c++) begin
                game_tik = ($urandom_range(0, 3) == 0);
                step(1);
                reset = 1'b1;
            end
        end
        key_right_n = 1'b1;
        key_left_n  = 1'b1;
        game_tik    = 1'b0;
        step(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
